execute_stage_md: RTL and testbench
===================================

# execute_stage_md

Parametrised execute stage with RV32M multiply/divide support for the five-stage pipeline. Between the ID/EX and EX/MEM boundaries it:

- forwards operands,
- evaluates ALU, multiply and full-compare branch operations,
- runs a serial divider that stalls the front end,
- registers results into EX/MEM with stall and flush control.

## Interface

- XLEN, 32, datapath width (32 or 64).
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_e  in  1  instruction in E is real (not a bubble).
- flush_e  in  1  squash instruction in E and abort any division.
- stall_m  in  1  hold EX/MEM register contents.
- reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e  in  1 each  decoded controls.
- result_src_e  in  2  writeback select, passed through.
- alu_op_e  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, A MUL, B MULH, C DIV, D DIVU, E REM, F REMU.
- funct3_e  in  3  branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU encodings).
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  in  XLEN each  operands and PCs.
- rd_e  in  5  destination register.
- forward_a_e, forward_b_e  in  2  0 register file, 1 result_w, 2 alu_result_m.
- result_w  in  XLEN  writeback forward value.
- pc_src_e  out  1  redirect fetch.
- pc_target_e  out  XLEN  pc_e + imm_ext_e.
- busy_e  out  1  divider occupying E; the hazard unit holds F/D/E.
- valid_m, reg_write_m, mem_write_m  out  1 each  registered controls.
- result_src_m  out  2  registered writeback select.
- rd_m  out  5  registered destination register.
- alu_result_m, write_data_m, pc_plus4_m  out  XLEN each  registered data.

## Operation

- **Operand selection**
  - src_a = 3:1 forward mux.
  - fwd_b = 3:1 forward mux; src_b = alu_src_e ? imm_ext_e : fwd_b.
  - write_data_m captures fwd_b.
- **Shifts:** shift amount = src_b[log2(XLEN)-1:0].
- **Multiply:** MUL returns the low XLEN bits of the signed product; MULH returns the high XLEN bits. Both are single-cycle.
- **Branch:** taken per funct3 on src_a vs fwd_b. Comparisons are signed for BLT/BGE and unsigned for BLTU/BGEU.
  - pc_src_e = valid_e & ~flush_e & ((branch_e & taken) | jump_e).
- **Divider FSM:** IDLE → BUSY → DONE → IDLE.
  - IDLE: a valid, unflushed DIV/DIVU/REM/REMU with a non-special operand pair raises busy_e combinationally. On the next edge the divider captures magnitudes and signs and moves to BUSY with count = XLEN-1.
  - BUSY: one restoring step per cycle, busy_e = 1. After the count = 0 step, move to DONE.
  - DONE: busy_e = 0. Sign-corrected quotient or remainder drives the result mux. The EX/MEM load (when stall_m = 0) returns the FSM to IDLE; while stall_m = 1 the FSM stays in DONE.
- **Divide special cases:** resolved in one cycle with no FSM entry.
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
- **EX/MEM register**
  - stall_m = 1: hold all contents.
  - flush_e = 1, or busy_e = 1 in IDLE/BUSY: load a bubble (all controls 0, valid_m 0, data 0).
  - Otherwise: load the E values.
- **Abort:** flush_e in any state returns the FSM to IDLE on the next edge and discards the divider result.

## Timing

- Reset: every output register is 0 and the FSM is IDLE. A reset mid-division aborts it; no partial result ever appears.
- Non-divide ops: result visible at the M outputs one edge after E.
- Divide latency, first E cycle to the EX/MEM load:
  - XLEN+2 edges (issue, XLEN steps, DONE).
  - 34 for XLEN=32.
  - M receives XLEN+1 bubbles in the meantime.
- pc_src_e and pc_target_e are combinational in the E cycle.
- Forward inputs may change during BUSY without effect, because operands are latched at issue.

## Configuration

- EXEC_MULDIV_EN defined: MUL/MULH, the divider FSM and busy_e logic are built.
- EXEC_MULDIV_EN undefined:
  - alu_op A–F yields result 0.
  - busy_e is tied 0.
  - The divider is not instantiated.
  - Base-ALU timing is unchanged.

## Structure

- Shared package exec_pkg holds:
  - alu_op encodings;
  - result_src encodings;
  - branch funct3 constants;
  - the divider state enum (IDLE, BUSY, DONE).
- One sub-module, div_iter: the serial restoring divider. It has a start/abort/done handshake, is parameterised by XLEN, and returns unsigned quotient and remainder. Sign correction and the special-case bypass live in the parent.

## Test plan

- ADD with forward_a_e=2, alu_result_m=5, imm 7, alu_src_e=1 → alu_result_m=12 after one edge.
- BLTU with src_a=0xFFFFFFFF, fwd_b=1 → pc_src_e=0. BLT on the same operands → pc_src_e=1, pc_target_e=pc_e+imm.
- DIV -7/2 → busy_e high for 33 cycles, 33 bubbles at M, then alu_result_m=0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF.
- DIVU 9/0 → alu_result_m=0xFFFFFFFF next edge with busy_e never high. DIV 0x80000000/-1 → 0x80000000.
- flush_e during the 10th BUSY cycle → FSM IDLE next edge, valid_m=0, no result written. Repeat with rst asserted mid-division → all outputs 0.
- DONE with stall_m=1 for 3 cycles → result held, FSM stays DONE, loaded exactly once when stall_m drops. Build without EXEC_MULDIV_EN → MUL gives 0, busy_e constant 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, writeback select, branch
// conditions and the divider state enum.
package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_MUL  = 4'hA;
    localparam logic [3:0] ALU_MULH = 4'hB;
    localparam logic [3:0] ALU_DIV  = 4'hC;
    localparam logic [3:0] ALU_DIVU = 4'hD;
    localparam logic [3:0] ALU_REM  = 4'hE;
    localparam logic [3:0] ALU_REMU = 4'hF;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // DIV/DIVU/REM/REMU occupy encodings C..F
    function automatic logic is_div_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/execute_stage_md_div_iter.sv
// Serial restoring divider on unsigned magnitudes: one quotient bit per cycle,
// start/abort/ack handshake, result held in DONE until acknowledged.
module div_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            ack,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN);

    div_state_t      state_reg, state_next;
    logic [XLEN-1:0] q_reg, r_reg, d_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN:0]   r_shift, diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract
    assign r_shift = {r_reg, q_reg[XLEN-1]};
    assign diff    = r_shift - {1'b0, d_reg};

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_next = BUSY;
                BUSY:    if (count_reg == '0) state_next = DONE;
                DONE:    if (ack) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                q_reg     <= dividend;
                r_reg     <= '0;
                d_reg     <= divisor;
                count_reg <= CW'(XLEN - 1);
            end else if (state_reg == BUSY) begin
                q_reg     <= {q_reg[XLEN-2:0], ~diff[XLEN]};
                r_reg     <= diff[XLEN] ? r_shift[XLEN-1:0] : diff[XLEN-1:0];
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign busy      = (state_reg == BUSY);
    assign done      = (state_reg == DONE);
    assign quotient  = q_reg;
    assign remainder = r_reg;

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage with forwarding, ALU, branch resolution and EX/MEM register.
// RV32M multiply/divide is built only when EXEC_MULDIV_EN is defined.
module execute_stage_md
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_e,
    input  logic            flush_e,
    input  logic            stall_m,
    input  logic            reg_write_e,
    input  logic            mem_write_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic            alu_src_e,
    input  logic [1:0]      result_src_e,
    input  logic [3:0]      alu_op_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] imm_ext_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    input  logic [4:0]      rd_e,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] result_w,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            busy_e,
    output logic            valid_m,
    output logic            reg_write_m,
    output logic            mem_write_m,
    output logic [1:0]      result_src_m,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus4_m
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, mdu_res;
    logic [SHW-1:0]  shamt;
    logic            taken;

    always_comb begin
        case (forward_a_e)
            2'd1:    src_a = result_w;
            2'd2:    src_a = alu_result_m;
            default: src_a = rd1_e;
        endcase
        case (forward_b_e)
            2'd1:    fwd_b = result_w;
            2'd2:    fwd_b = alu_result_m;
            default: fwd_b = rd2_e;
        endcase
    end

    assign src_b = alu_src_e ? imm_ext_e : fwd_b;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        case (alu_op_e)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLL:  alu_res = src_a << shamt;
            ALU_SRL:  alu_res = src_a >> shamt;
            ALU_SRA:  alu_res = $signed(src_a) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            default:  alu_res = mdu_res;
        endcase
    end

    // Branches compare against the forwarded rs2, never the immediate
    always_comb begin
        case (funct3_e)
            F3_BEQ:  taken = (src_a == fwd_b);
            F3_BNE:  taken = (src_a != fwd_b);
            F3_BLT:  taken = ($signed(src_a) < $signed(fwd_b));
            F3_BGE:  taken = ($signed(src_a) >= $signed(fwd_b));
            F3_BLTU: taken = (src_a < fwd_b);
            F3_BGEU: taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign pc_src_e    = valid_e & ~flush_e & ((branch_e & taken) | jump_e);
    assign pc_target_e = pc_e + imm_ext_e;

`ifdef EXEC_MULDIV_EN
    logic [2*XLEN-1:0] prod;
    logic              div_signed, div_rem, div_zero, div_ovf, div_special, div_go;
    logic              div_busy, div_done, div_idle, a_neg, b_neg;
    logic              neg_res_reg, rem_sel_reg;
    logic [XLEN-1:0]   a_mag, b_mag, q_u, r_u, div_raw, div_res, special_res;

    assign prod = {{XLEN{src_a[XLEN-1]}}, src_a} * {{XLEN{src_b[XLEN-1]}}, src_b};

    assign div_signed  = ~alu_op_e[0];
    assign div_rem     = alu_op_e[1];
    assign a_neg       = div_signed & src_a[XLEN-1];
    assign b_neg       = div_signed & src_b[XLEN-1];
    assign a_mag       = a_neg ? -src_a : src_a;
    assign b_mag       = b_neg ? -src_b : src_b;
    assign div_zero    = (src_b == '0);
    assign div_ovf     = div_signed & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);
    assign div_special = div_zero | div_ovf;
    assign special_res = div_rem ? (div_zero ? src_a : '0) : (div_zero ? '1 : src_a);
    assign div_go      = valid_e & ~flush_e & is_div_op(alu_op_e) & ~div_special;
    assign div_idle    = ~div_busy & ~div_done;
    assign busy_e      = (div_go & div_idle) | div_busy;

    // Result sign is fixed at issue so later forwarding changes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_res_reg <= 1'b0;
            rem_sel_reg <= 1'b0;
        end else if (div_go & div_idle) begin
            neg_res_reg <= div_rem ? a_neg : (a_neg ^ b_neg);
            rem_sel_reg <= div_rem;
        end
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .abort     (flush_e),
        .ack       (~stall_m),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (q_u),
        .remainder (r_u)
    );

    assign div_raw = rem_sel_reg ? r_u : q_u;
    assign div_res = neg_res_reg ? -div_raw : div_raw;

    always_comb begin
        case (alu_op_e)
            ALU_MUL:  mdu_res = prod[XLEN-1:0];
            ALU_MULH: mdu_res = prod[2*XLEN-1:XLEN];
            default:  mdu_res = div_done ? div_res : (div_special ? special_res : '0);
        endcase
    end
`else
    assign mdu_res = '0;
    assign busy_e  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
        end else if (!stall_m) begin
            if (flush_e || busy_e) begin
                valid_m      <= 1'b0;
                reg_write_m  <= 1'b0;
                mem_write_m  <= 1'b0;
                result_src_m <= RES_ALU;
                rd_m         <= '0;
                alu_result_m <= '0;
                write_data_m <= '0;
                pc_plus4_m   <= '0;
            end else begin
                valid_m      <= valid_e;
                reg_write_m  <= reg_write_e;
                mem_write_m  <= mem_write_e;
                result_src_m <= result_src_e;
                rd_m         <= rd_e;
                alu_result_m <= alu_res;
                write_data_m <= fwd_b;
                pc_plus4_m   <= pc_plus4_e;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed testbench for execute_stage_md; multiply/divide scenarios are
// selected by EXEC_MULDIV_EN to match the build under test.
module tb_execute_stage_md;
    import exec_pkg::*;

    logic        clk, rst, valid_e, flush_e, stall_m;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e;
    logic [1:0]  result_src_e, forward_a_e, forward_b_e;
    logic [3:0]  alu_op_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
    logic [4:0]  rd_e;
    logic        pc_src_e, busy_e, valid_m, reg_write_m, mem_write_m;
    logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
    logic [1:0]  result_src_m;
    logic [4:0]  rd_m;

    int total = 0;
    int bad   = 0;

    execute_stage_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e), .stall_m(stall_m),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
        .jump_e(jump_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e),
        .alu_op_e(alu_op_e), .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd_e(rd_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .busy_e(busy_e),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_e = 0; flush_e = 0; stall_m = 0; reg_write_e = 0; mem_write_e = 0;
        branch_e = 0; jump_e = 0; alu_src_e = 0; result_src_e = 0; alu_op_e = 0;
        funct3_e = 0; rd1_e = 0; rd2_e = 0; imm_ext_e = 0; pc_e = 0; pc_plus4_e = 0;
        rd_e = 0; forward_a_e = 0; forward_b_e = 0; result_w = 0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_e = 1; alu_op_e = op; rd1_e = a; rd2_e = b; alu_src_e = 0;
        forward_a_e = 0; forward_b_e = 0; reg_write_e = 1; rd_e = 5'd7;
        branch_e = 0; jump_e = 0; mem_write_e = 0; result_src_e = RES_ALU; flush_e = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) tick();
        total++;
        if ({valid_m, reg_write_m, mem_write_m, result_src_m, rd_m, alu_result_m,
             write_data_m, pc_plus4_m} !== '0) begin
            bad++;
            $display("FAIL reset_m_regs got alu=%h wd=%h valid=%b", alu_result_m, write_data_m, valid_m);
        end
        total++;
        if (busy_e !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_e); end
        @(negedge clk);
        rst = 0;
        tick();
        $display("reset: m regs cleared, busy=%b", busy_e);
    endtask

    task automatic test_forward();
        set_op(ALU_ADD, 32'd5, 32'd0);
        tick();
        total++;
        if (alu_result_m !== 32'd5) begin bad++; $display("FAIL fwd_seed got=%h exp=5", alu_result_m); end
        set_op(ALU_ADD, 32'd99, 32'h55);
        forward_a_e = 2; alu_src_e = 1; imm_ext_e = 32'd7; rd_e = 5'd9;
        result_src_e = RES_PC4; mem_write_e = 1; pc_plus4_e = 32'h204;
        tick();
        total++;
        if (alu_result_m !== 32'd12) begin bad++; $display("FAIL fwd_a_m got=%h exp=c", alu_result_m); end
        total++;
        if ({valid_m, mem_write_m, rd_m, result_src_m, pc_plus4_m, write_data_m} !==
            {1'b1, 1'b1, 5'd9, RES_PC4, 32'h204, 32'h55}) begin
            bad++;
            $display("FAIL fwd_ctrl got rd=%0d rs=%0d pc4=%h wd=%h", rd_m, result_src_m, pc_plus4_m, write_data_m);
        end
        set_op(ALU_SUB, 32'd10, 32'd99);
        forward_b_e = 1; result_w = 32'd3;
        tick();
        total++;
        if ({alu_result_m, write_data_m} !== {32'd7, 32'd3}) begin
            bad++;
            $display("FAIL fwd_b_w got alu=%h wd=%h exp alu=7 wd=3", alu_result_m, write_data_m);
        end
        set_op(ALU_ADD, 32'd0, 32'd1);
        forward_a_e = 1; result_w = 32'h100;
        tick();
        total++;
        if (alu_result_m !== 32'h101) begin bad++; $display("FAIL fwd_a_w got=%h exp=101", alu_result_m); end
        $display("forward: last alu_result_m=%h", alu_result_m);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic test_alu_ops();
        alu_vec_t v[10];
        v[0] = '{ALU_SUB,  32'h8000_00F0, 32'h34, 32'h8000_00BC};
        v[1] = '{ALU_AND,  32'h8000_00F0, 32'h34, 32'h0000_0030};
        v[2] = '{ALU_OR,   32'h8000_00F0, 32'h34, 32'h8000_00F4};
        v[3] = '{ALU_XOR,  32'h8000_00F0, 32'h34, 32'h8000_00C4};
        v[4] = '{ALU_SLL,  32'h8000_00F0, 32'h34, 32'h0F00_0000};
        v[5] = '{ALU_SRL,  32'h8000_00F0, 32'h34, 32'h0000_0800};
        v[6] = '{ALU_SRA,  32'h8000_00F0, 32'h34, 32'hFFFF_F800};
        v[7] = '{ALU_SLT,  32'h8000_00F0, 32'h34, 32'h0000_0001};
        v[8] = '{ALU_SLTU, 32'h8000_00F0, 32'h34, 32'h0000_0000};
        v[9] = '{ALU_SLL,  32'h0000_0001, 32'h24, 32'h0000_0010};
        for (int i = 0; i < 10; i++) begin
            set_op(v[i].op, v[i].a, v[i].b);
            tick();
            total++;
            if (alu_result_m !== v[i].exp) begin
                bad++;
                $display("FAIL alu_op%0h got=%h exp=%h", v[i].op, alu_result_m, v[i].exp);
            end
            $display("alu op=%h a=%h b=%h -> %h", v[i].op, v[i].a, v[i].b, alu_result_m);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        br;
        logic        jmp;
        logic        vld;
        logic        fl;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } br_vec_t;

    task automatic test_branch();
        br_vec_t v[10];
        v[0] = '{F3_BLTU, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'd1, 1'b0};
        v[1] = '{F3_BLT,  1, 0, 1, 0, 32'hFFFF_FFFF, 32'd1, 1'b1};
        v[2] = '{F3_BGE,  1, 0, 1, 0, 32'hFFFF_FFFF, 32'd1, 1'b0};
        v[3] = '{F3_BGEU, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'd1, 1'b1};
        v[4] = '{F3_BEQ,  1, 0, 1, 0, 32'd5, 32'd5, 1'b1};
        v[5] = '{F3_BNE,  1, 0, 1, 0, 32'd5, 32'd5, 1'b0};
        v[6] = '{F3_BEQ,  1, 0, 1, 0, 32'd5, 32'd6, 1'b0};
        v[7] = '{F3_BNE,  0, 1, 1, 0, 32'd5, 32'd5, 1'b1};
        v[8] = '{F3_BLT,  1, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 1'b0};
        v[9] = '{F3_BLT,  1, 0, 1, 1, 32'hFFFF_FFFF, 32'd1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_op(ALU_SUB, v[i].a, v[i].b);
            reg_write_e = 0; alu_src_e = 1; imm_ext_e = 32'h40; pc_e = 32'h100;
            funct3_e = v[i].f3; branch_e = v[i].br; jump_e = v[i].jmp;
            valid_e = v[i].vld; flush_e = v[i].fl;
            #1;
            total++;
            if (pc_src_e !== v[i].exp) begin
                bad++;
                $display("FAIL branch_%0d got=%b exp=%b", i, pc_src_e, v[i].exp);
            end
            $display("branch f3=%b a=%h b=%h -> pc_src=%b", v[i].f3, v[i].a, v[i].b, pc_src_e);
        end
        total++;
        if (pc_target_e !== 32'h140) begin bad++; $display("FAIL pc_target got=%h exp=140", pc_target_e); end
        flush_e = 0;
        tick();
    endtask

    task automatic test_stall_flush();
        set_op(ALU_XOR, 32'hF, 32'h3);
        tick();
        set_op(ALU_ADD, 32'd1, 32'd1);
        stall_m = 1;
        repeat (2) tick();
        total++;
        if ({valid_m, alu_result_m} !== {1'b1, 32'hC}) begin
            bad++;
            $display("FAIL stall_hold got=%h exp=c", alu_result_m);
        end
        stall_m = 0; flush_e = 1;
        tick();
        total++;
        if ({valid_m, reg_write_m, alu_result_m} !== '0) begin
            bad++;
            $display("FAIL flush_bubble got valid=%b alu=%h", valid_m, alu_result_m);
        end
        flush_e = 0;
        tick();
        total++;
        if (alu_result_m !== 32'd2) begin bad++; $display("FAIL after_flush got=%h exp=2", alu_result_m); end
        $display("stall/flush: final alu_result_m=%h", alu_result_m);
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int n);
        set_op(op, a, b);
        n = 0;
        while (busy_e === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        tick();
        res = alu_result_m;
        valid_e = 0;
    endtask

    task automatic test_mul();
        logic [31:0] v[4][4];
        v[0] = '{{28'd0, ALU_MUL},  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB};
        v[1] = '{{28'd0, ALU_MULH}, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF};
        v[2] = '{{28'd0, ALU_MULH}, 32'h4000_0000, 32'd4, 32'h0000_0001};
        v[3] = '{{28'd0, ALU_MUL},  32'h4000_0000, 32'd4, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            set_op(v[i][0][3:0], v[i][1], v[i][2]);
            tick();
            total++;
            if ({busy_e, alu_result_m} !== {1'b0, v[i][3]}) begin
                bad++;
                $display("FAIL mul_%0d got=%h busy=%b exp=%h", i, alu_result_m, busy_e, v[i][3]);
            end
            $display("mul op=%h -> %h", v[i][0][3:0], alu_result_m);
        end
    endtask

    task automatic test_div_long();
        int n = 0;
        int bubbles = 0;
        logic [31:0] res;
        set_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        while (busy_e === 1'b1 && n < 100) begin
            n++;
            tick();
            if (n == 5) begin forward_a_e = 1; result_w = 32'hDEAD_BEEF; end
            if (valid_m === 1'b0 && alu_result_m === 32'd0) bubbles++;
        end
        forward_a_e = 0;
        total++;
        if (n != 33) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=33", n); end
        total++;
        if (bubbles != 33) begin bad++; $display("FAIL div_bubbles got=%0d exp=33", bubbles); end
        tick();
        total++;
        if ({valid_m, alu_result_m} !== {1'b1, 32'hFFFF_FFFD}) begin
            bad++;
            $display("FAIL div_neg7_2 got=%h exp=fffffffd", alu_result_m);
        end
        $display("div -7/2: busy=%0d bubbles=%0d -> %h", n, bubbles, alu_result_m);
        run_div(ALU_REM, 32'hFFFF_FFF9, 32'd2, res, n);
        total++;
        if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_neg7_2 got=%h exp=ffffffff", res); end
        run_div(ALU_DIV, 32'd7, 32'hFFFF_FFFE, res, n);
        total++;
        if (res !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_7_neg2 got=%h exp=fffffffd", res); end
        run_div(ALU_REM, 32'd7, 32'hFFFF_FFFE, res, n);
        total++;
        if (res !== 32'd1) begin bad++; $display("FAIL rem_7_neg2 got=%h exp=1", res); end
        run_div(ALU_REMU, 32'd100, 32'd7, res, n);
        total++;
        if (res !== 32'd2) begin bad++; $display("FAIL remu_100_7 got=%h exp=2", res); end
        $display("div misc: last remu 100/7 -> %h", res);
    endtask

    task automatic test_div_special();
        logic [31:0] v[4][4];
        v[0] = '{{28'd0, ALU_DIVU}, 32'd9, 32'd0, 32'hFFFF_FFFF};
        v[1] = '{{28'd0, ALU_REMU}, 32'd9, 32'd0, 32'd9};
        v[2] = '{{28'd0, ALU_DIV},  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[3] = '{{28'd0, ALU_REM},  32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 4; i++) begin
            set_op(v[i][0][3:0], v[i][1], v[i][2]);
            #1;
            total++;
            if (busy_e !== 1'b0) begin bad++; $display("FAIL special_busy_%0d got=%b exp=0", i, busy_e); end
            tick();
            total++;
            if ({valid_m, alu_result_m} !== {1'b1, v[i][3]}) begin
                bad++;
                $display("FAIL special_%0d got=%h exp=%h", i, alu_result_m, v[i][3]);
            end
            $display("div special op=%h a=%h b=%h -> %h", v[i][0][3:0], v[i][1], v[i][2], alu_result_m);
        end
    endtask

    task automatic test_div_abort();
        set_op(ALU_DIV, 32'd100, 32'd7);
        repeat (10) tick();
        flush_e = 1;
        tick();
        flush_e = 0; valid_e = 0;
        #1;
        total++;
        if ({valid_m, busy_e} !== 2'b00) begin
            bad++;
            $display("FAIL abort_idle got valid_m=%b busy=%b exp 0 0", valid_m, busy_e);
        end
        set_op(ALU_ADD, 32'd2, 32'd3);
        tick();
        total++;
        if ({valid_m, alu_result_m} !== {1'b1, 32'd5}) begin
            bad++;
            $display("FAIL abort_next got=%h exp=5", alu_result_m);
        end
        $display("div abort: next op -> %h", alu_result_m);
    endtask

    task automatic test_div_reset();
        set_op(ALU_ADD, 32'd1, 32'd2);
        tick();
        stall_m = 1;
        set_op(ALU_DIV, 32'd100, 32'd7);
        repeat (5) tick();
        rst = 1;
        #1;
        idle_inputs();
        #1;
        total++;
        if ({valid_m, reg_write_m, mem_write_m, result_src_m, rd_m, alu_result_m,
             write_data_m, pc_plus4_m, busy_e} !== '0) begin
            bad++;
            $display("FAIL reset_mid_div got alu=%h valid=%b busy=%b", alu_result_m, valid_m, busy_e);
        end
        @(negedge clk);
        rst = 0;
        set_op(ALU_ADD, 32'd4, 32'd4);
        tick();
        total++;
        if ({valid_m, alu_result_m} !== {1'b1, 32'd8}) begin
            bad++;
            $display("FAIL reset_next got=%h exp=8", alu_result_m);
        end
        $display("div reset: next op -> %h", alu_result_m);
    endtask

    task automatic test_div_stall();
        int n = 0;
        set_op(ALU_DIV, 32'd100, 32'd7);
        while (busy_e === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        stall_m = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({busy_e, valid_m} !== 2'b00) begin
                bad++;
                $display("FAIL done_stall_%0d got busy=%b valid_m=%b", i, busy_e, valid_m);
            end
        end
        stall_m = 0;
        tick();
        total++;
        if ({valid_m, alu_result_m} !== {1'b1, 32'd14}) begin
            bad++;
            $display("FAIL done_load got=%h exp=e", alu_result_m);
        end
        valid_e = 0;
        tick();
        total++;
        if ({valid_m, busy_e} !== 2'b00) begin
            bad++;
            $display("FAIL done_once got valid_m=%b busy=%b", valid_m, busy_e);
        end
        $display("div stall in done: loaded 100/7 -> 14 once");
    endtask
`else
    task automatic test_muldiv_disabled();
        logic [3:0] ops[3];
        ops[0] = ALU_MUL; ops[1] = ALU_DIV; ops[2] = ALU_DIVU;
        for (int i = 0; i < 3; i++) begin
            set_op(ops[i], 32'd9, (i == 2) ? 32'd0 : 32'd3);
            #1;
            total++;
            if (busy_e !== 1'b0) begin bad++; $display("FAIL nomd_busy_%0d got=%b exp=0", i, busy_e); end
            tick();
            total++;
            if ({valid_m, alu_result_m} !== {1'b1, 32'd0}) begin
                bad++;
                $display("FAIL nomd_op%0h got=%h exp=0", ops[i], alu_result_m);
            end
            $display("muldiv disabled op=%h -> %h", ops[i], alu_result_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_alu_ops();
        test_branch();
        test_stall_flush();
`ifdef EXEC_MULDIV_EN
        test_mul();
        test_div_long();
        test_div_special();
        test_div_abort();
        test_div_reset();
        test_div_stall();
`else
        test_muldiv_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
